// File: rtl/hazard_pkg.sv
// Shared constants, stage indices and helpers for the Tuse/Tnew hazard unit.
package hazard_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned T_W    = 3;
  localparam int unsigned SEL_W  = 2;

  // A Tuse of all-ones marks an operand the instruction does not read.
  localparam logic [T_W-1:0] TUSE_NONE = '1;

  localparam int unsigned STG_E = 1;
  localparam int unsigned STG_M = 2;
  localparam int unsigned STG_W = 3;

  typedef struct packed {
    logic [REG_AW-1:0] dst;
    logic [T_W-1:0]    tnew;
  } sb_entry_t;

  function automatic logic [T_W-1:0] sat_dec(input logic [T_W-1:0] t);
    return (t == '0) ? '0 : t - T_W'(1);
  endfunction

endpackage

// File: rtl/hazard_md_counter.sv
// HI/LO busy tracker: remembers an MDU start sitting in E, then counts the unit's latency down.
module hazard_md_counter #(
  parameter int unsigned MUL_LAT = 5,
  parameter int unsigned DIV_LAT = 10
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic div,
  output logic busy,
  output logic start_e
);

  localparam int unsigned MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int unsigned CNT_W   = $clog2(MAX_LAT + 1);

  logic [CNT_W-1:0] count;
  logic             div_e;

  // The latency count starts as the accepted start leaves E; start_e covers the cycle before.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_e <= 1'b0;
      div_e   <= 1'b0;
      count   <= '0;
    end else begin
      start_e <= start;
      div_e   <= start & div;
      if (start_e) begin
        count <= div_e ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
      end else if (count != '0) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  assign busy = (count != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Tuse/Tnew hazard unit: shift scoreboard of in-flight writers, D-stage stall and forward selects.
// Defining MDU_BUSY_EN adds HI/LO busy tracking for mult/div; otherwise the md ports are ignored.
module hazard_scoreboard #(
  parameter int unsigned NUM_STAGES = 3,
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned T_W        = 3,
  parameter int unsigned MUL_LAT    = 5,
  parameter int unsigned DIV_LAT    = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs,
  input  logic [REG_AW-1:0] d_rt,
  input  logic [T_W-1:0]    d_rs_use,
  input  logic [T_W-1:0]    d_rt_use,
  input  logic [REG_AW-1:0] d_dst,
  input  logic [T_W-1:0]    d_tnew,
  input  logic              d_md_start,
  input  logic              d_md_div,
  input  logic              d_md_use,
  output logic              stall,
  output logic [1:0]        fwd_rs_sel,
  output logic [1:0]        fwd_rt_sel,
  output logic              md_busy
);

  import hazard_pkg::*;

  logic [REG_AW-1:0] sb_dst  [1:NUM_STAGES];
  logic [T_W-1:0]    sb_tnew [1:NUM_STAGES];

  logic [NUM_STAGES:1] hit_rs;
  logic [NUM_STAGES:1] hit_rt;

  logic             rs_hit;
  logic             rt_hit;
  logic [SEL_W-1:0] rs_stage;
  logic [SEL_W-1:0] rt_stage;
  logic [T_W-1:0]   rs_tnew;
  logic [T_W-1:0]   rt_tnew;
  logic             hazard_rs;
  logic             hazard_rt;
  logic             md_hz;
  logic             accept;

  assign accept = d_valid & ~stall;

  // Scoreboard shift: a stalled D cycle pushes a bubble into E.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= NUM_STAGES; k++) begin
        sb_dst[k]  <= '0;
        sb_tnew[k] <= '0;
      end
    end else begin
      if (accept) begin
        sb_dst[STG_E]  <= d_dst;
        sb_tnew[STG_E] <= d_tnew;
      end else begin
        sb_dst[STG_E]  <= '0;
        sb_tnew[STG_E] <= '0;
      end
      for (int k = STG_E + 1; k <= NUM_STAGES; k++) begin
        sb_dst[k]  <= sb_dst[k-1];
        sb_tnew[k] <= sat_dec(sb_tnew[k-1]);
      end
    end
  end

  // Per-stage operand match; register 0 and unused operands never match.
  for (genvar k = 1; k <= NUM_STAGES; k++) begin : g_match
    assign hit_rs[k] = (sb_dst[k] == d_rs) && (d_rs != '0) && (d_rs_use != TUSE_NONE);
    assign hit_rt[k] = (sb_dst[k] == d_rt) && (d_rt != '0) && (d_rt_use != TUSE_NONE);
  end

  // Walk oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    rs_hit   = 1'b0;
    rt_hit   = 1'b0;
    rs_stage = '0;
    rt_stage = '0;
    rs_tnew  = '0;
    rt_tnew  = '0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (hit_rs[k]) begin
        rs_hit   = 1'b1;
        rs_stage = SEL_W'(k);
        rs_tnew  = sb_tnew[k];
      end
      if (hit_rt[k]) begin
        rt_hit   = 1'b1;
        rt_stage = SEL_W'(k);
        rt_tnew  = sb_tnew[k];
      end
    end
  end

  assign hazard_rs = rs_hit && (rs_tnew > d_rs_use);
  assign hazard_rt = rt_hit && (rt_tnew > d_rt_use);

  assign stall = d_valid & (hazard_rs | hazard_rt | md_hz);

  assign fwd_rs_sel = (rs_hit && (rs_tnew == '0) && !stall) ? rs_stage : '0;
  assign fwd_rt_sel = (rt_hit && (rt_tnew == '0) && !stall) ? rt_stage : '0;

`ifdef MDU_BUSY_EN
  logic md_start_e;

  hazard_md_counter #(
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT)
  ) u_md_counter (
    .clk     (clk),
    .reset   (reset),
    .start   (accept & d_md_start),
    .div     (d_md_div),
    .busy    (md_busy),
    .start_e (md_start_e)
  );

  assign md_hz = d_md_use & (md_busy | md_start_e);
`else
  logic md_unused;

  assign md_unused = ^{d_md_start, d_md_div, d_md_use, 32'(MUL_LAT), 32'(DIV_LAT)};
  assign md_busy   = 1'b0;
  assign md_hz     = 1'b0;
`endif

endmodule
